// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: widths, ALU control
// codes, controller state encoding and the opcode legality check.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// The shared 32-bit ALU: ADD, SUB and AND, with a zero result for any
// other control code. Purely combinational; results wrap modulo 2^DATA_W.
module alu
  import alu_pkg::*;
#(
  parameter int W = alu_pkg::DATA_W
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [OP_W-1:0] alu_control,
  output logic [W-1:0]    result
);

  // Select the operation; unsupported codes produce zero.
  always_comb begin
    result = '0;
    case (alu_control)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters with round-robin arbitration.
// One operation in flight: IDLE accepts, EXEC computes from latched
// operands, RESP holds the registered response until it is consumed.
module alu_share_ctrl #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_id,
  output logic              rsp_illegal
);
  import alu_pkg::*;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_id_q, rsp_id_d;
  logic              rsp_illegal_q, rsp_illegal_d;

  logic              grant_vld;
  logic              grant_id;
  logic [DATA_W-1:0] alu_result;

  alu #(
    .W(DATA_W)
  ) u_alu (
    .a          (a_q),
    .b          (b_q),
    .alu_control(op_q),
    .result     (alu_result)
  );

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = ~last_grant_q;
    end else if (req0_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end else if (req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
  end

  assign req0_ready = (state_q == ST_IDLE) && grant_vld && !grant_id;
  assign req1_ready = (state_q == ST_IDLE) && grant_vld && grant_id;

  // Next-state and datapath updates for accept, execute and response hold.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    id_d          = id_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_id_d      = rsp_id_q;
    rsp_illegal_d = rsp_illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          a_d          = grant_id ? req1_a  : req0_a;
          b_d          = grant_id ? req1_b  : req0_b;
          op_d         = grant_id ? req1_op : req0_op;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d  = alu_result;
        rsp_id_d      = id_q;
        rsp_illegal_d = !is_legal_op(op_q);
        rsp_valid_d   = 1'b1;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      id_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_id_q      <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      id_q          <= id_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_id_q      <= rsp_id_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a transaction-level reference
// model checked against the DUT on every falling clock edge.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        rsp_valid, rsp_id, rsp_illegal;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DATA_W(32), .OP_W(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_id(rsp_id), .rsp_illegal(rsp_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Operation semantics straight from the opcode table.
  function automatic logic [32:0] golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    // bit 32 = illegal flag, bits 31:0 = result
    case (op)
      3'b010:  return {1'b0, a + b};
      3'b110:  return {1'b0, a - b};
      3'b000:  return {1'b0, a & b};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  bit          m_busy = 0;      // an accepted op still being computed
  bit          m_pend = 0;      // a response is being offered
  bit          m_last = 1;      // requester served most recently
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_res = '0;
  bit          m_id, m_rid = 0, m_ill = 0;

  function automatic int m_pick();
    if (m_busy || m_pend) return -1;
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    logic [32:0] r;
    g = m_pick();
    if (reset) begin
      m_busy = 0; m_pend = 0; m_last = 1; m_res = '0; m_rid = 0; m_ill = 0;
    end else if (m_pend) begin
      if (rsp_ready) m_pend = 0;
    end else if (m_busy) begin
      r = golden(m_op, m_a, m_b);
      m_res = r[31:0]; m_ill = r[32]; m_rid = m_id;
      m_busy = 0; m_pend = 1;
    end else if (g >= 0) begin
      m_id   = (g == 1);
      m_op   = m_id ? req1_op : req0_op;
      m_a    = m_id ? req1_a  : req0_a;
      m_b    = m_id ? req1_b  : req0_b;
      m_last = m_id;
      m_busy = 1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int g;
    g = m_pick();
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, g == 0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, g == 1});
    chk("rsp_valid",  {31'b0, rsp_valid},  {31'b0, m_pend});
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_id",     {31'b0, rsp_id},      {31'b0, m_rid});
    chk("rsp_illegal",{31'b0, rsp_illegal}, {31'b0, m_ill});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // Wait for the handshake of requester n, then drop its valid.
  task automatic wait_ready(input int n);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
        seen = 1;
        break;
      end
    end
    chk($sformatf("accept_req%0d", n), {31'b0, seen}, 32'd1);
    step();
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Wait for rsp_valid and check the response against literal values.
  task automatic wait_rsp(input logic [31:0] er, input bit eid, input bit eill, output int lat);
    bit seen = 0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    chk("rsp_arrived", {31'b0, seen}, 32'd1);
    chk("lit_result",  rsp_result, er);
    chk("lit_id",      {31'b0, rsp_id}, {31'b0, eid});
    chk("lit_illegal", {31'b0, rsp_illegal}, {31'b0, eill});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid",  {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);

    // 1: single ADD with two-cycle latency
    step();
    set_req(0, 3'b010, 32'd5, 32'd7);
    wait_ready(0);
    wait_rsp(32'd12, 1'b0, 1'b0, lat);
    chk("latency", lat, 32'd2);

    // 2: both valid after reset; req0 wins the first tie, then req1
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 3'b110, 32'd10, 32'd3);
    set_req(1, 3'b000, 32'hF0, 32'h3C);
    wait_ready(0);
    wait_rsp(32'd7, 1'b0, 1'b0, lat);
    wait_ready(1);
    wait_rsp(32'h30, 1'b1, 1'b0, lat);

    // 3: wrap-around
    step();
    set_req(0, 3'b110, 32'h0, 32'h1);
    wait_ready(0);
    wait_rsp(32'hFFFF_FFFF, 1'b0, 1'b0, lat);
    step();
    set_req(1, 3'b010, 32'hFFFF_FFFF, 32'h2);
    wait_ready(1);
    wait_rsp(32'h1, 1'b1, 1'b0, lat);

    // 4: illegal op, then a legal one clears the flag
    step();
    set_req(1, 3'b111, 32'd1, 32'd1);
    wait_ready(1);
    wait_rsp(32'd0, 1'b1, 1'b1, lat);
    step();
    set_req(0, 3'b010, 32'd2, 32'd3);
    wait_ready(0);
    wait_rsp(32'd5, 1'b0, 1'b0, lat);

    // 5: backpressure while req1 waits
    step();
    rsp_ready = 1'b0;
    set_req(0, 3'b000, 32'hFF00, 32'h0FF0);
    wait_ready(0);
    set_req(1, 3'b010, 32'd100, 32'd23);
    wait_rsp(32'h0F00, 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid",  {31'b0, rsp_valid}, 32'd1);
      chk("stall_result", rsp_result, 32'h0F00);
      chk("stall_ready1", {31'b0, req1_ready}, 32'd0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_ready1_still_low", {31'b0, req1_ready}, 32'd0);
    @(negedge clk);
    chk("release_ready1_next", {31'b0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    wait_rsp(32'd123, 1'b1, 1'b0, lat);

    // 6a: reset during EXEC
    step();
    set_req(0, 3'b010, 32'd1, 32'd1);
    wait_ready(0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_exec_valid",  {31'b0, rsp_valid}, 32'd0);
      chk("rst_exec_result", rsp_result, 32'd0);
    end

    // 6b: reset during RESP
    step();
    rsp_ready = 1'b0;
    set_req(1, 3'b010, 32'd40, 32'd2);
    wait_ready(1);
    wait_rsp(32'd42, 1'b1, 1'b0, lat);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid",  {31'b0, rsp_valid}, 32'd0);
    chk("rst_resp_result", rsp_result, 32'd0);
    chk("rst_resp_id",     {31'b0, rsp_id}, 32'd0);

    // Normal service afterwards
    step();
    set_req(1, 3'b110, 32'd100, 32'd1);
    wait_ready(1);
    wait_rsp(32'd99, 1'b1, 1'b0, lat);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
